lfsr_checker: RTL and testbench

Receive-side companion to the 8-bit pseudo-random sequence generator. It consumes the generator's 3-bit tap output stream and self-synchronises to it: it recovers the generator's full 8-bit state from the stream, then predicts every subsequent sample. It reports lock, per-sample mismatches and a saturating error count. It sits beside the generator in the game/test datapath and qualifies that the stream is intact after transport or replay.

---
 rtl/lfsr_pkg.sv | 27 ++
 rtl/lfsr_checker_if.sv | 31 +++
 rtl/lfsr_checker.sv | 138 +++++++++++++
 tb/tb_lfsr_checker.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit pseudo-random generator and its checker.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Both ends of the link call lfsr_next/lfsr_taps from here, so the sequence
// and the observed tap positions are defined in exactly one place.
package lfsr_pkg;

  localparam int LFSR_W = 8;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_VERIFY  = 2'd1,
    ST_LOCKED  = 2'd2
  } lfsr_state_e;

  // One generator step: shift left, feedback from bits 7,5,4,1 into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[1]};
  endfunction

  // Bits of the state that appear on the wire: {s[6], s[3], s[0]}.
  function automatic logic [2:0] lfsr_taps(input logic [LFSR_W-1:0] s);
    return {s[6], s[3], s[0]};
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Sample/status bundle between a tap-stream source and lfsr_checker.
// Latency: n/a (wiring only).
// Backpressure: none; the sink accepts one sample per cycle whenever en is high.
//
// Signals:
//   clear     source -> checker  synchronous restart
//   en        source -> checker  sample strobe
//   r_in[2:0] source -> checker  generator taps {s[6], s[3], s[0]}
//   locked    checker -> source  tracking the sequence
//   err_pulse checker -> source  one-cycle mismatch pulse
//   err_count checker -> source  saturating mismatch count while locked
//   state     checker -> source  FSM state for debug
interface lfsr_checker_if;
  logic       clear;
  logic       en;
  logic [2:0] r_in;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [1:0] state;

  modport master (
    output clear, en, r_in,
    input  locked, err_pulse, err_count, state
  );

  modport slave (
    input  clear, en, r_in,
    output locked, err_pulse, err_count, state
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit generator's 3-bit tap stream.
// Latency: all outputs registered; result of a sample appears the cycle after its en.
// Backpressure: none; accepts one sample every cycle en is high, never stalls.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         lfsr_checker_if.slave: clear/en/r_in in, locked/err_pulse/
//               err_count/state out
// Parameters:
//   VERIFY_LEN   matching samples after acquisition needed to lock (1..255)
//   LOSS_THRESH  consecutive mismatches while locked that drop lock (1..15)
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int VERIFY_LEN  = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  lfsr_checker_if.slave  bus
);

  localparam logic [7:0] VERIFY_LAST = 8'(VERIFY_LEN - 1);
  localparam logic [3:0] LOSS_LAST   = 4'(LOSS_THRESH - 1);

  lfsr_state_e       state_q;
  // Only the last seven acquired bits are kept: together with the current
  // r_in[0] they form the full 8-bit state on the 8th sample, and the oldest
  // bit would otherwise be shifted out unread.
  logic [LFSR_W-2:0] acq_q;
  logic [LFSR_W-1:0] pred_q;
  logic [2:0]        acq_cnt_q;
  logic [7:0]        ver_cnt_q;
  logic [3:0]        miss_cnt_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic [7:0]        err_count_q;

  logic [LFSR_W-1:0] acq_full;
  logic              sample_ok;

  // Generator state that was presented together with the current sample,
  // valid when this is the 8th acquisition sample.
  assign acq_full  = {acq_q, bus.r_in[0]};
  assign sample_ok = (bus.r_in == lfsr_taps(pred_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACQUIRE;
      acq_q       <= '0;
      pred_q      <= 8'h01;
      acq_cnt_q   <= '0;
      ver_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.clear) begin
        state_q     <= ST_ACQUIRE;
        acq_cnt_q   <= '0;
        ver_cnt_q   <= '0;
        miss_cnt_q  <= '0;
        locked_q    <= 1'b0;
        err_count_q <= '0;
      end else if (bus.en) begin
        case (state_q)
          ST_ACQUIRE: begin
            acq_q <= acq_full[LFSR_W-2:0];
            if (acq_cnt_q == 3'd7) begin
              acq_cnt_q <= '0;
              // An all-zero window cannot come from a legal generator state;
              // discard it and collect a fresh one.
              if (acq_full != '0) begin
                pred_q    <= lfsr_next(acq_full);
                ver_cnt_q <= '0;
                state_q   <= ST_VERIFY;
              end
            end else begin
              acq_cnt_q <= acq_cnt_q + 3'd1;
            end
          end

          ST_VERIFY: begin
            pred_q <= lfsr_next(pred_q);
            if (!sample_ok) begin
              err_pulse_q <= 1'b1;
              acq_cnt_q   <= '0;
              state_q     <= ST_ACQUIRE;
            end else if (ver_cnt_q == VERIFY_LAST) begin
              ver_cnt_q  <= '0;
              miss_cnt_q <= '0;
              locked_q   <= 1'b1;
              state_q    <= ST_LOCKED;
            end else begin
              ver_cnt_q <= ver_cnt_q + 8'd1;
            end
          end

          ST_LOCKED: begin
            // Keep advancing through errors: isolated corrupt samples must
            // not knock the prediction out of phase.
            pred_q <= lfsr_next(pred_q);
            if (!sample_ok) begin
              err_pulse_q <= 1'b1;
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
              if (miss_cnt_q == LOSS_LAST) begin
                miss_cnt_q <= '0;
                acq_cnt_q  <= '0;
                locked_q   <= 1'b0;
                state_q    <= ST_ACQUIRE;
              end else begin
                miss_cnt_q <= miss_cnt_q + 4'd1;
              end
            end else begin
              miss_cnt_q <= '0;
            end
          end

          default: begin
            acq_cnt_q <= '0;
            locked_q  <= 1'b0;
            state_q   <= ST_ACQUIRE;
          end
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed lock/loss/clear/reset scenarios plus
// randomized traffic, all scored against a behavioural model of the checker.
module tb_lfsr_checker;

  localparam int VLEN = 16;
  localparam int LT   = 4;

  typedef struct packed {
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [1:0] state;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_drive;

  lfsr_checker_if bus_if ();

  lfsr_checker #(.VERIFY_LEN(VLEN), .LOSS_THRESH(LT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_seen = 0;
  obs_t exp_q[$];

  // ---------------- reference model ----------------
  int gen;  // stimulus generator state
  int m_state, m_pred, m_good, m_miss, m_errs;
  bit m_pulse, m_lock;
  bit m_hist[$];

  function automatic int gen_next_i(int s);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 1)) & 1;
    return ((s << 1) | fb) & 255;
  endfunction

  function automatic int gen_taps_i(int s);
    return (((s >> 6) & 1) << 2) | (((s >> 3) & 1) << 1) | (s & 1);
  endfunction

  function automatic void model_reset();
    m_state = 0; m_pred = 1; m_good = 0; m_miss = 0; m_errs = 0;
    m_pulse = 0; m_lock = 0;
    m_hist.delete();
  endfunction

  function automatic void model_step(bit rst, bit c, bit e, int r);
    int s;
    int want;
    if (!rst) begin
      model_reset();
      return;
    end
    m_pulse = 0;
    if (c) begin
      m_state = 0; m_miss = 0; m_errs = 0; m_lock = 0;
      m_hist.delete();
    end else if (e) begin
      if (m_state == 0) begin
        m_hist.push_back(bit'(r & 1));
        if (m_hist.size() == 8) begin
          s = 0;
          foreach (m_hist[i]) s = (s << 1) | int'(m_hist[i]);
          m_hist.delete();
          if (s != 0) begin
            m_pred = gen_next_i(s);
            m_good = 0;
            m_state = 1;
          end
        end
      end else begin
        want = gen_taps_i(m_pred);
        m_pred = gen_next_i(m_pred);
        if (m_state == 1) begin
          if (r != want) begin
            m_pulse = 1; m_state = 0; m_hist.delete();
          end else begin
            m_good++;
            if (m_good == VLEN) begin m_state = 2; m_lock = 1; m_miss = 0; end
          end
        end else begin
          if (r != want) begin
            m_pulse = 1;
            if (m_errs < 255) m_errs++;
            m_miss++;
            if (m_miss == LT) begin
              m_state = 0; m_miss = 0; m_lock = 0; m_hist.delete();
            end
          end else begin
            m_miss = 0;
          end
        end
      end
    end
  endfunction

  function automatic obs_t model_obs();
    return '{locked: m_lock, err_pulse: m_pulse, err_count: 8'(m_errs), state: 2'(m_state)};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expected observation per cycle, popped after each edge.
  always begin
    obs_t e, a;
    @(posedge clk);
    #1;
    if (bus_if.err_pulse === 1'b1) pulse_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{locked: bus_if.locked, err_pulse: bus_if.err_pulse,
            err_count: bus_if.err_count, state: bus_if.state};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got lock=%b pulse=%b cnt=%0d st=%0d, expected lock=%b pulse=%b cnt=%0d st=%0d",
                 $time, a.locked, a.err_pulse, a.err_count, a.state,
                 e.locked, e.err_pulse, e.err_count, e.state);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [2:0] clean_r();
    return 3'(gen_taps_i(gen));
  endfunction

  task automatic step(input bit e, input bit c, input logic [2:0] r);
    @(negedge clk);
    rst_n        = rst_drive;
    bus_if.en    = e;
    bus_if.clear = c;
    bus_if.r_in  = r;
    model_step(rst_drive, c, e, int'(r));
    exp_q.push_back(model_obs());
    if (e) gen = gen_next_i(gen);
  endtask

  task automatic run_clean(input int n);
    repeat (n) step(1'b1, 1'b0, clean_r());
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Restart the checker, lock it on clean samples, checking the lock edge.
  task automatic lock_from_acquire(input string tag);
    run_clean(8 + VLEN - 1);
    settle();
    chk({tag, "_not_yet_locked"}, 32'(bus_if.locked), 32'd0);
    run_clean(1);
    settle();
    chk({tag, "_locked"}, 32'(bus_if.locked), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit e, c;
    logic [2:0] flip;

    rst_drive    = 1'b0;
    rst_n        = 1'b0;
    bus_if.en    = 1'b0;
    bus_if.clear = 1'b0;
    bus_if.r_in  = 3'd0;
    gen          = 8'hA5;
    model_reset();

    // Reset and release.
    repeat (3) step(1'b0, 1'b0, 3'd0);
    rst_drive = 1'b1;
    step(1'b0, 1'b0, 3'd0);
    settle();
    chk("reset_state", 32'(bus_if.state), 32'd0);
    chk("reset_locked", 32'(bus_if.locked), 32'd0);
    chk("reset_err_count", 32'(bus_if.err_count), 32'd0);

    // Seed 0xA5, en every cycle: lock after exactly 24 samples, then clean.
    lock_from_acquire("a5");
    run_clean(1000);
    settle();
    chk("a5_err_count_clean", 32'(bus_if.err_count), 32'd0);
    chk("a5_still_locked", 32'(bus_if.locked), 32'd1);

    // Seed 0x01, en one cycle in three.
    step(1'b0, 1'b1, 3'd0);
    gen = 1;
    pulse_seen = 0;
    n = 0;
    while (n < 24) begin
      step(1'b0, 1'b0, clean_r());
      step(1'b0, 1'b0, clean_r());
      step(1'b1, 1'b0, clean_r());
      n++;
      if (n == 23) begin
        settle();
        chk("sparse_not_yet_locked", 32'(bus_if.locked), 32'd0);
      end
    end
    settle();
    chk("sparse_locked", 32'(bus_if.locked), 32'd1);
    chk("sparse_no_err_pulse", 32'(pulse_seen), 32'd0);

    // Single corrupted sample while locked.
    step(1'b1, 1'b0, clean_r() ^ 3'b010);
    settle();
    chk("flip_pulse", 32'(bus_if.err_pulse), 32'd1);
    chk("flip_err_count", 32'(bus_if.err_count), 32'd1);
    chk("flip_locked", 32'(bus_if.locked), 32'd1);
    run_clean(1);
    settle();
    chk("flip_next_ok", 32'(bus_if.err_pulse), 32'd0);

    // Four consecutive corruptions drop lock; relock 24 samples later.
    step(1'b0, 1'b1, 3'd0);
    lock_from_acquire("pre_loss");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, clean_r() ^ 3'($urandom_range(1, 7)));
      if (i == 2) begin
        settle();
        chk("loss_3_still_locked", 32'(bus_if.locked), 32'd1);
      end
    end
    settle();
    chk("loss_4_unlocked", 32'(bus_if.locked), 32'd0);
    chk("loss_err_count", 32'(bus_if.err_count), 32'd4);
    lock_from_acquire("relock");
    chk("relock_err_count", 32'(bus_if.err_count), 32'd4);

    // Lose lock again, get into VERIFY, then clear.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, clean_r() ^ 3'b100);
    run_clean(8 + 5);
    settle();
    chk("mid_verify_state", 32'(bus_if.state), 32'd1);
    chk("mid_verify_err_count", 32'(bus_if.err_count), 32'd8);
    step(1'b1, 1'b1, clean_r());
    settle();
    chk("clear_state", 32'(bus_if.state), 32'd0);
    chk("clear_err_count", 32'(bus_if.err_count), 32'd0);

    // Asynchronous reset while locked.
    lock_from_acquire("pre_reset");
    rst_drive = 1'b0;
    step(1'b1, 1'b0, clean_r());
    #1;
    chk("reset_async_locked", 32'(bus_if.locked), 32'd0);
    chk("reset_async_state", 32'(bus_if.state), 32'd0);
    step(1'b1, 1'b0, clean_r());
    rst_drive = 1'b1;
    lock_from_acquire("post_reset");

    // Error counter saturates at 255 without losing lock.
    for (int k = 0; k < 86; k++) begin
      repeat (LT - 1) step(1'b1, 1'b0, clean_r() ^ 3'b001);
      run_clean(1);
    end
    settle();
    chk("sat_err_count", 32'(bus_if.err_count), 32'd255);
    chk("sat_locked", 32'(bus_if.locked), 32'd1);

    // All-zero input never produces lock.
    step(1'b0, 1'b1, 3'd0);
    repeat (100) step(1'b1, 1'b0, 3'd0);
    settle();
    chk("zero_state", 32'(bus_if.state), 32'd0);
    chk("zero_locked", 32'(bus_if.locked), 32'd0);

    // Randomized traffic: random seeds, en gaps, sparse corruption and clears.
    for (int round = 0; round < 6; round++) begin
      step(1'b0, 1'b1, 3'd0);
      gen = $urandom_range(1, 255);
      for (int i = 0; i < 400; i++) begin
        e = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 299) == 0);
        flip = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        step(e, c, clean_r() ^ flip);
      end
    end

    settle();
    settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
